// File: rtl/btn_debounce_sync.sv
// Multi-channel button conditioner: 2-flop synchronizer, per-channel debounce FSM, press/release strobes.
// Optional auto-repeat of press_pulse while held is enabled by defining BTN_DEBOUNCE_REPEAT_EN.
module btn_debounce_sync #(
  parameter int NUM_BTN         = 5,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] rel_pulse
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    PRESSED    = 2'd2,
    REL_WAIT   = 2'd3
  } state_t;

  localparam logic [NUM_BTN-1:0] RELEASED_RAW = {NUM_BTN{ACTIVE_LOW}};
  localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);

  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;
  logic [NUM_BTN-1:0] pressed_d;
  logic [NUM_BTN-1:0] level_q;
  logic [NUM_BTN-1:0] press_q;
  logic [NUM_BTN-1:0] rel_q;
  state_t             state_q [NUM_BTN];
  logic [CNT_W-1:0]   cnt_q   [NUM_BTN];

`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam logic [31:0] REP_FIRST  = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] REP_RELOAD = 32'(REPEAT_DELAY - REPEAT_PERIOD);
  logic [31:0] rep_q [NUM_BTN];
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

  // Normalized after the second flop: 1 always means pressed.
  assign pressed_d = sync2_q ^ RELEASED_RAW;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= RELEASED_RAW;
      sync2_q <= RELEASED_RAW;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
`ifdef BTN_DEBOUNCE_REPEAT_EN
        rep_q[i]   <= '0;
`endif
      end
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      press_q <= '0;
      rel_q   <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        case (state_q[i])
          IDLE: begin
            if (pressed_d[i]) begin
              state_q[i] <= PRESS_WAIT;
              cnt_q[i]   <= CNT_ONE;
            end
          end
          PRESS_WAIT: begin
            if (!pressed_d[i]) begin
              state_q[i] <= IDLE;
              cnt_q[i]   <= '0;
            end else if (cnt_q[i] == CNT_LAST) begin
              state_q[i] <= PRESSED;
              level_q[i] <= 1'b1;
              press_q[i] <= 1'b1;
              cnt_q[i]   <= '0;
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_ONE;
            end
          end
          PRESSED: begin
            if (!pressed_d[i]) begin
              state_q[i] <= REL_WAIT;
              cnt_q[i]   <= CNT_ONE;
            end
          end
          REL_WAIT: begin
            if (pressed_d[i]) begin
              state_q[i] <= PRESSED;
              cnt_q[i]   <= '0;
            end else if (cnt_q[i] == CNT_LAST) begin
              state_q[i] <= IDLE;
              level_q[i] <= 1'b0;
              rel_q[i]   <= 1'b1;
              cnt_q[i]   <= '0;
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_ONE;
            end
          end
          default: begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
          end
        endcase
`ifdef BTN_DEBOUNCE_REPEAT_EN
        // Repeat timer only advances while held in PRESSED; any exit restarts it from zero.
        if (state_q[i] == PRESSED && pressed_d[i]) begin
          if (rep_q[i] == REP_FIRST) begin
            press_q[i] <= 1'b1;
            rep_q[i]   <= REP_RELOAD;
          end else begin
            rep_q[i] <= rep_q[i] + 32'd1;
          end
        end else begin
          rep_q[i] <= '0;
        end
`endif
      end
    end
  end

  assign btn_level   = level_q;
  assign press_pulse = press_q;
  assign rel_pulse   = rel_q;

endmodule

// File: tb/tb_btn_debounce_sync.sv
// Bench for btn_debounce_sync (DEBOUNCE_CYCLES=4, active-low buttons); repeat checks when BTN_DEBOUNCE_REPEAT_EN is defined.
module tb_btn_debounce_sync;

  localparam int NB = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] press_pulse;
  logic [NB-1:0] rel_pulse;

  always #5 clk = ~clk;

  btn_debounce_sync #(
    .NUM_BTN(NB),
    .CNT_W(16),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(1'b1),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .rel_pulse(rel_pulse)
  );

  typedef struct {
    logic [NB-1:0] raw;
    logic [NB-1:0] lvl;
    logic [NB-1:0] pr;
    logic [NB-1:0] rl;
  } vec_t;

  typedef struct {
    logic [NB-1:0] lvl;
    logic [NB-1:0] pr;
    logic [NB-1:0] rl;
    int            idx;
  } exp_t;

  vec_t tbl [$];
  exp_t sb  [$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   vec_no   = 0;

  task automatic add(input logic [NB-1:0] raw, input int n,
                     input logic [NB-1:0] lvl, input logic [NB-1:0] pr, input logic [NB-1:0] rl);
    vec_t v;
    v.raw = raw; v.lvl = lvl; v.pr = pr; v.rl = rl;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at vector %0d: got %b, expected %b", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input logic rst, input logic [NB-1:0] raw,
                      input logic [NB-1:0] lvl, input logic [NB-1:0] pr, input logic [NB-1:0] rl);
    exp_t e;
    reset   = rst;
    btn_raw = raw;
    e.lvl = lvl; e.pr = pr; e.rl = rl; e.idx = vec_no;
    vec_no++;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("btn_level", e.idx, btn_level, e.lvl);
    chk("press_pulse", e.idx, press_pulse, e.pr);
    chk("rel_pulse", e.idx, rel_pulse, e.rl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] pr_e;

    // Idle / single press on ch0 (pulse 5 vectors after raw change).
    add(5'h1F, 3, 5'h00, 5'h00, 5'h00);
    add(5'h1E, 5, 5'h00, 5'h00, 5'h00);
    add(5'h1E, 1, 5'h01, 5'h01, 5'h00);
    add(5'h1E, 4, 5'h01, 5'h00, 5'h00);
    // 2-cycle release glitch is rejected, then a real release.
    add(5'h1F, 2, 5'h01, 5'h00, 5'h00);
    add(5'h1E, 6, 5'h01, 5'h00, 5'h00);
    add(5'h1F, 5, 5'h01, 5'h00, 5'h00);
    add(5'h1F, 1, 5'h00, 5'h00, 5'h01);
    add(5'h1F, 3, 5'h00, 5'h00, 5'h00);
    // Bouncing ch1: low 3, high 1, low 3, high -> nothing; then held low -> one pulse.
    add(5'h1D, 3, 5'h00, 5'h00, 5'h00);
    add(5'h1F, 1, 5'h00, 5'h00, 5'h00);
    add(5'h1D, 3, 5'h00, 5'h00, 5'h00);
    add(5'h1F, 3, 5'h00, 5'h00, 5'h00);
    add(5'h1D, 5, 5'h00, 5'h00, 5'h00);
    add(5'h1D, 1, 5'h02, 5'h02, 5'h00);
    add(5'h1D, 4, 5'h02, 5'h00, 5'h00);
    add(5'h1F, 5, 5'h02, 5'h00, 5'h00);
    add(5'h1F, 1, 5'h00, 5'h00, 5'h02);
    add(5'h1F, 2, 5'h00, 5'h00, 5'h00);
    // Simultaneous ch2 + ch4.
    add(5'h0B, 5, 5'h00, 5'h00, 5'h00);
    add(5'h0B, 1, 5'h14, 5'h14, 5'h00);
    add(5'h0B, 3, 5'h14, 5'h00, 5'h00);
    add(5'h1F, 5, 5'h14, 5'h00, 5'h00);
    add(5'h1F, 1, 5'h00, 5'h00, 5'h14);
    add(5'h1F, 2, 5'h00, 5'h00, 5'h00);

    reset   = 1'b1;
    btn_raw = 5'h1F;
    // Reset state.
    step(1'b1, 5'h1F, 5'h00, 5'h00, 5'h00);
    step(1'b1, 5'h1F, 5'h00, 5'h00, 5'h00);

    foreach (tbl[i]) step(1'b0, tbl[i].raw, tbl[i].lvl, tbl[i].pr, tbl[i].rl);

    // Reset while ch3 is mid-debounce (cnt=2), held through reset, re-qualified afterwards.
    step(1'b0, 5'h17, 5'h00, 5'h00, 5'h00);
    step(1'b0, 5'h17, 5'h00, 5'h00, 5'h00);
    step(1'b0, 5'h17, 5'h00, 5'h00, 5'h00);
    step(1'b0, 5'h17, 5'h00, 5'h00, 5'h00);
    step(1'b1, 5'h17, 5'h00, 5'h00, 5'h00);
    for (int k = 0; k < 5; k++) step(1'b0, 5'h17, 5'h00, 5'h00, 5'h00);
    step(1'b0, 5'h17, 5'h08, 5'h08, 5'h00);
    step(1'b0, 5'h17, 5'h08, 5'h00, 5'h00);
    for (int k = 0; k < 5; k++) step(1'b0, 5'h1F, 5'h08, 5'h00, 5'h00);
    step(1'b0, 5'h1F, 5'h00, 5'h00, 5'h08);
    step(1'b0, 5'h1F, 5'h00, 5'h00, 5'h00);

    // Long hold on ch0: acceptance at t=5, repeats (if built) at +10 then every 4 while held.
    for (int t = 0; t < 36; t++) begin
      pr_e = 5'h00;
      if (t == 5) pr_e = 5'h01;
`ifdef BTN_DEBOUNCE_REPEAT_EN
      if (t >= 15 && ((t - 15) % 4) == 0) pr_e = 5'h01;
`endif
      step(1'b0, 5'h1E, (t >= 5) ? 5'h01 : 5'h00, pr_e, 5'h00);
    end
    for (int t = 36; t < 41; t++) step(1'b0, 5'h1F, 5'h01, 5'h00, 5'h00);
    step(1'b0, 5'h1F, 5'h00, 5'h00, 5'h01);
    for (int t = 0; t < 6; t++) step(1'b0, 5'h1F, 5'h00, 5'h00, 5'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
